// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared types and helpers for the byte-serial add/sub sequencer
package adder_seq_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 16;
  localparam int MAX_W     = BYTE_W * MAX_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Callers zero-extend their operand to MAX_W so one helper serves every NBYTES.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [MAX_W-1:0] vec,
                                                 input logic [3:0]       idx);
    return vec[BYTE_W*idx +: BYTE_W];
  endfunction

endpackage

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - drives an external 8-bit adder LSB-first for NBYTES-wide add/sub
// Optional zero/neg/ovf flag logic is built only when ADDER_SEQ_FLAGS_EN is defined.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic                     cin_in,
  input  logic [BYTE_W*NBYTES-1:0] opa,
  input  logic [BYTE_W*NBYTES-1:0] opb,
  output logic                     ready,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     zero,
  output logic                     neg,
  output logic                     ovf,
  output logic [BYTE_W-1:0]        add_a,
  output logic [BYTE_W-1:0]        add_b,
  output logic                     add_cin,
  input  logic [BYTE_W-1:0]        add_sum,
  input  logic                     add_cout
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;
`ifdef ADDER_SEQ_FLAGS_EN
  logic             nz_q, nz_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
`ifdef ADDER_SEQ_FLAGS_EN
    nz_d   = nz_q;
    zero_d = zero_q;
    neg_d  = neg_q;
    ovf_d  = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start && ready_q) begin
          a_d     = opa;
          b_d     = op_sub ? ~opb : opb;
          carry_d = op_sub | cin_in;
          idx_d   = '0;
          state_d = RUN;
`ifdef ADDER_SEQ_FLAGS_EN
          nz_d = 1'b0;
`endif
        end
      end
      RUN: begin
        add_a   = byte_sel(MAX_W'(a_q), 4'(idx_q));
        add_b   = byte_sel(MAX_W'(b_q), 4'(idx_q));
        add_cin = carry_q;
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) result_d[BYTE_W*i +: BYTE_W] = add_sum;
        end
        carry_d = add_cout;
`ifdef ADDER_SEQ_FLAGS_EN
        nz_d = nz_q | (|add_sum);
`endif
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          cout_d  = add_cout;
`ifdef ADDER_SEQ_FLAGS_EN
          // Final byte carries the sign, so all three flags settle here.
          zero_d = ~(nz_q | (|add_sum));
          neg_d  = add_sum[BYTE_W-1];
          ovf_d  = (a_q[W-1] == b_q[W-1]) && (add_sum[BYTE_W-1] != a_q[W-1]);
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
`ifdef ADDER_SEQ_FLAGS_EN
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
`ifdef ADDER_SEQ_FLAGS_EN
      nz_q   <= nz_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      ovf_q  <= ovf_d;
`endif
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
`ifdef ADDER_SEQ_FLAGS_EN
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl (NBYTES=4, ADDER_SEQ_FLAGS_EN aware)
module tb_adder_seq_ctrl;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        cin;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, start, op_sub, cin_in;
  logic [31:0] opa, opb;
  logic        ready, done, cout, zero, neg, ovf;
  logic [31:0] result;
  logic [7:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_count = 0;
  int   n_pushed = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  adder_seq_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub), .cin_in(cin_in),
    .opa(opa), .opb(opb), .ready(ready), .done(done), .result(result),
    .cout(cout), .zero(zero), .neg(neg), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  function automatic vec_t vec(input int i);
    case (i)
      0:       return '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0};
      1:       return '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
      2:       return '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0};
      3:       return '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b1};
      4:       return '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
      5:       return '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b1};
      6:       return '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
      7:       return '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 1'b1, 1'b0};
      default: return '{32'h00000100, 32'h00000001, 1'b1, 1'b1, 32'h000000FF, 1'b1, 1'b0, 1'b0, 1'b0};
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input vec_t v);
    exp_t e;
    e.res = v.res;
    e.c   = v.c;
`ifdef ADDER_SEQ_FLAGS_EN
    e.z = v.z;
    e.n = v.n;
    e.v = v.v;
`else
    e.z = 1'b0;
    e.n = 1'b0;
    e.v = 1'b0;
`endif
    sb_q.push_back(e);
    n_pushed++;
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic drive(input vec_t v);
    opa    = v.a;
    opb    = v.b;
    op_sub = v.sub;
    cin_in = v.cin;
    start  = 1'b1;
  endtask

  task automatic do_op(input vec_t v, input bit chk_lat);
    int cyc;
    wait_ready();
    drive(v);
    push(v);
    @(negedge clk);
    cyc    = 1;
    start  = 1'b0;
    opa    = $urandom;
    opb    = $urandom;
    op_sub = ~op_sub;
    cin_in = ~cin_in;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    if (chk_lat) begin
      check("done_latency", 32'(cyc), 32'd5);
      @(negedge clk);
      check("ready_after_done", 32'(ready), 32'd1);
      check("done_cleared", 32'(done), 32'd0);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_count++;
      check("done_width", 32'(prev_done), 32'd0);
      check("sb_empty_at_done", 32'(sb_q.size() == 0), 32'd0);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("result", result, e.res);
        check("cout", 32'(cout), 32'(e.c));
        check("zero", 32'(zero), 32'(e.z));
        check("neg", 32'(neg), 32'(e.n));
        check("ovf", 32'(ovf), 32'(e.v));
      end
    end
    prev_done = done;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   dc;
    int   acc[$];
    vec_t v;
    rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; cin_in = 1'b0; opa = '0; opb = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    check("rst_flags", 32'({zero, neg, ovf}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vec(i), i == 0);

    // Start during RUN with other operands must be ignored.
    v = vec(5);
    wait_ready();
    drive(v);
    push(v);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    opa = 32'hFFFFFFFF; opb = 32'h0000FFFF; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("sb_drained_after_ignored_start", 32'(sb_q.size()), 32'd0);

    // Reset while idx=2 is in flight: no done, state cleared.
    wait_ready();
    drive(vec(7));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    dc = done_count;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", 32'(ready), 32'd1);
    check("midrun_rst_result", result, 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_add_a", 32'(add_a), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrun_rst_no_done", 32'(done_count), 32'(dc));

    // Start held high: accepts every NBYTES+2 cycles.
    v = vec(7);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 0) drive(v);
      if (ready) begin
        acc.push_back(c);
        push(v);
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("held_start_accepts", 32'(acc.size()), 32'd4);
    for (int k = 1; k < acc.size(); k++) check("held_start_spacing", 32'(acc[k] - acc[k-1]), 32'd6);

    check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    check("done_total", 32'(done_count), 32'(n_pushed));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Multi-precision add/subtract sequencer. It runs one external 8-bit carry adder byte-serially, LSB first, to add or subtract NBYTES-wide operands.
- Owns the operand/result registers, the carry chain between bytes, and a start/ready/done handshake to the requesting control logic.
- Sits between the microsequencer and the shared 8-bit adder slice.

Parameters:
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 2..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted only when ready=1.
- op_sub  in  1  0 = A+B+cin_in; 1 = A-B (A + ~B + 1), cin_in ignored.
- cin_in  in  1  carry-in for add, used for chaining wider ops.
- opa  in  W  operand A, sampled on accept.
- opb  in  W  operand B, sampled on accept.
- ready  out  1  idle, can accept start.
- done  out  1  one-cycle pulse: result/cout valid.
- result  out  W  sum/difference, held until next accept.
- cout  out  1  final carry. For subtract, 1 = no borrow.
- zero  out  1  result==0 (FLAGS_EN).
- neg  out  1  result MSB (FLAGS_EN).
- ovf  out  1  signed overflow (FLAGS_EN).
- add_a  out  8  adder A byte.
- add_b  out  8  adder B byte (already inverted for subtract).
- add_cin  out  1  adder carry-in.
- add_sum  in  8  adder sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  adder carry-out.

Behaviour:
- Single clock clk; reset rst_n asynchronous, active-low.
- Reset values: state=IDLE, ready=1, done=0, result=0, cout=0, flags=0, add_a=add_b=0, add_cin=0, byte index=0, carry register=0.
- FSM has three states:
  - IDLE: ready=1; adder inputs driven 0. On start&ready:
    - latch opa, and opb (or ~opb when op_sub=1);
    - carry <= op_sub ? 1 : cin_in; idx <= 0; go to RUN.
  - RUN: ready=0. Combinationally add_a = A[8*idx+:8], add_b = B'[8*idx+:8], add_cin = carry. At each edge:
    - result[8*idx+:8] <= add_sum; carry <= add_cout;
    - if idx == NBYTES-1 go to DONE, else idx <= idx+1.
  - DONE: done=1 for exactly one cycle, ready=0, cout = carry; next state IDLE unconditionally.
- Latency: accept edge at cycle 0; RUN occupies cycles 1..NBYTES; done high in cycle NBYTES+1; ready high again in cycle NBYTES+2. Throughput is one op per NBYTES+2 cycles.
- start while ready=0 is ignored; it is not queued. Operand changes after accept have no effect.
- start held high continuously: a new op is accepted on the first cycle ready=1.
- result is updated byte-by-byte during RUN. It is valid only with done and holds afterwards until the next accept.
- Reset mid-RUN: immediate return to IDLE; partial result cleared; no done pulse.
- add_sum/add_cout are sampled only in RUN; external adder glitches elsewhere are irrelevant.

Optional Feature:
- Macro: ADDER_SEQ_FLAGS_EN.
- Defined:
  - zero is accumulated as OR of every captured sum byte, inverted at DONE.
  - neg = result[W-1].
  - ovf = (A[W-1] == B'[W-1]) && (add_sum[7] != A[W-1]) on the final byte.
  - All flags update in the DONE cycle and hold with result.
- Not defined: zero/neg/ovf ports still exist, tied to 0, and no flag logic is synthesized.

Decomposition:
- Package adder_seq_pkg holds:
  - BYTE_W = 8;
  - state enum {IDLE, RUN, DONE} with 2-bit encoding;
  - function byte_sel(vector, idx).
- No sub-module: the 8-bit adder stays external so it can be shared or arbitrated. The FSM and registers live in one module.

Test Plan:
All scenarios use NBYTES=4.
1. opa=0x000000FF, opb=0x00000001, add, cin_in=0 -> result=0x00000100, cout=0; done exactly in cycle 5 after accept; ready back in cycle 6.
2. opa=0xFFFFFFFF, opb=0x00000001, add -> result=0x00000000, cout=1, zero=1, ovf=0 (flags with ADDER_SEQ_FLAGS_EN).
3. opa=0x00000005, opb=0x00000007, op_sub=1 -> result=0xFFFFFFFE, cout=0 (borrow), neg=1.
4. opa=0x7FFFFFFF, opb=0x00000001, add -> result=0x80000000, ovf=1, neg=1. Also 0+0 with cin_in=1 -> result=0x00000001.
5. Accept op, then pulse start with other operands in cycle 2 -> ignored, first result unchanged. Then assert rst_n=0 during RUN idx=2 -> ready=1, result=0, no done pulse.
6. start held high for 20 cycles with fixed operands -> ops accepted every 6 cycles, each done pulse one cycle wide, results identical; macro undefined -> zero/neg/ovf constant 0.
